// File: rtl/counter_share_arb.sv
// Round-robin arbiter sharing one up/down counter among N requesters.
// Grant is combinational (0 cycles); count/wrap_p/gnt_id/busy update at the granting edge.
// Ungranted requesters hold their command; the counter never moves without a grant.
module counter_share_arb #(
  parameter int N   = 4,
  parameter int W   = 3,
  parameter int SAT = 0,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [2*N-1:0]   op,
  input  logic [W*N-1:0]   ld_data,
  output logic [N-1:0]     gnt,
  output logic [W-1:0]     count,
  output logic             wrap_p,
  output logic [IDW-1:0]   gnt_id,
  output logic             busy
);

  localparam logic [W-1:0]   CMAX = {W{1'b1}};
  localparam logic [IDW:0]   NL   = (IDW+1)'(N);
  localparam logic [IDW-1:0] NM1  = IDW'(N - 1);

  localparam logic [1:0] OP_INC   = 2'b00;
  localparam logic [1:0] OP_DEC   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Per-requester views of the flattened command buses.
  logic [1:0]   op_a [N];
  logic [W-1:0] ld_a [N];

  for (genvar i = 0; i < N; i++) begin : g_split
    assign op_a[i] = op[2*i +: 2];
    assign ld_a[i] = ld_data[W*i +: W];
  end

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;
  logic [IDW:0]   sum;
  logic           found;
  logic [1:0]     wop;
  logic [W-1:0]   wld;
  logic [W-1:0]   cnt_nxt;
  logic           wrap_nxt;

  // Pick the first requester at or after ptr, wrapping modulo N; reset masks every grant.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= NL) begin
        sum = sum - NL;
      end
      idx = sum[IDW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (rst) begin
      found = 1'b0;
    end
  end

  // One-hot grant and the winner's command.
  always_comb begin
    gnt = '0;
    if (found) begin
      gnt[win] = 1'b1;
    end
    wop     = op_a[win];
    wld     = ld_a[win];
    ptr_nxt = (win == NM1) ? '0 : win + 1'b1;
  end

  // Counter result for the winning command; limit hits either wrap or stick depending on SAT.
  always_comb begin
    cnt_nxt  = count;
    wrap_nxt = 1'b0;
    case (wop)
      OP_INC: begin
        if (count == CMAX) begin
          wrap_nxt = 1'b1;
          cnt_nxt  = (SAT != 0) ? count : '0;
        end else begin
          cnt_nxt = count + 1'b1;
        end
      end
      OP_DEC: begin
        if (count == '0) begin
          wrap_nxt = 1'b1;
          cnt_nxt  = (SAT != 0) ? count : CMAX;
        end else begin
          cnt_nxt = count - 1'b1;
        end
      end
      OP_LOAD:  cnt_nxt = wld;
      OP_CLEAR: cnt_nxt = '0;
      default:  cnt_nxt = count;
    endcase
  end

  // Apply the granted command; reset wins over any grant in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wrap_p <= 1'b0;
      gnt_id <= '0;
      busy   <= 1'b0;
      ptr    <= '0;
    end else begin
      busy   <= |gnt;
      wrap_p <= found & wrap_nxt;
      if (found) begin
        count  <= cnt_nxt;
        gnt_id <= win;
        ptr    <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_counter_share_arb.sv
// Bench for counter_share_arb: a wrapping (SAT=0) and a saturating (SAT=1) instance
// share the same requester stimulus; directed scenarios then a randomized run against
// a behavioural model of arbitration and counting.
module tb_counter_share_arb;

  localparam int N    = 4;
  localparam int W    = 3;
  localparam int IDW  = 2;
  localparam int MAXV = (1 << W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [2*N-1:0]   op;
  logic [W*N-1:0]   ld_data;

  logic [N-1:0]     gnt0, gnt1;
  logic [W-1:0]     count0, count1;
  logic             wrap0, wrap1;
  logic [IDW-1:0]   id0, id1;
  logic             busy0, busy1;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_ptr = 0, m_cnt0 = 0, m_cnt1 = 0, m_id = 0, m_busy = 0, m_wrap0 = 0, m_wrap1 = 0;

  always #5 clk = ~clk;

  counter_share_arb #(.N(N), .W(W), .SAT(0), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .ld_data(ld_data),
    .gnt(gnt0), .count(count0), .wrap_p(wrap0), .gnt_id(id0), .busy(busy0)
  );

  counter_share_arb #(.N(N), .W(W), .SAT(1), .IDW(IDW)) dut_sat (
    .clk(clk), .rst(rst), .req(req), .op(op), .ld_data(ld_data),
    .gnt(gnt1), .count(count1), .wrap_p(wrap1), .gnt_id(id1), .busy(busy1)
  );

  function automatic int model_winner();
    if (rst) return -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    int w;
    g = '0;
    w = model_winner();
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  task automatic set_cmd(input int i, input int o, input int d);
    req[i]          = 1'b1;
    op[2*i +: 2]    = 2'(o);
    ld_data[W*i +: W] = W'(d);
  endtask

  // Advance one edge and let the model apply the same edge.
  task automatic tick();
    int w, o, d;
    w = model_winner();
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_cnt0 = 0; m_cnt1 = 0; m_id = 0; m_busy = 0; m_wrap0 = 0; m_wrap1 = 0;
    end else begin
      m_busy  = (w >= 0) ? 1 : 0;
      m_wrap0 = 0;
      m_wrap1 = 0;
      if (w >= 0) begin
        o = int'(op[2*w +: 2]);
        d = int'(ld_data[W*w +: W]);
        case (o)
          0: begin
            m_cnt0 = m_cnt0 + 1;
            if (m_cnt0 > MAXV) begin m_cnt0 = 0; m_wrap0 = 1; end
            if (m_cnt1 == MAXV) m_wrap1 = 1; else m_cnt1 = m_cnt1 + 1;
          end
          1: begin
            m_cnt0 = m_cnt0 - 1;
            if (m_cnt0 < 0) begin m_cnt0 = MAXV; m_wrap0 = 1; end
            if (m_cnt1 == 0) m_wrap1 = 1; else m_cnt1 = m_cnt1 - 1;
          end
          2: begin m_cnt0 = d; m_cnt1 = d; end
          default: begin m_cnt0 = 0; m_cnt1 = 0; end
        endcase
        m_id  = w;
        m_ptr = (w + 1) % N;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    logic [N-1:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    rst = 1'b1; req = '1; op = '0; ld_data = '0;
    #1;
    checks++; if (gnt0 !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt0); end
    tick(); tick();
    checks++; if (gnt0 !== 4'b0000) begin errors++; $display("FAIL reset_gnt_held got=%b exp=0000", gnt0); end
    checks++; if (count0 !== 3'd0 || count1 !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d/%0d exp=0", count0, count1); end
    checks++; if (wrap0 !== 1'b0 || busy0 !== 1'b0 || id0 !== 2'd0) begin errors++; $display("FAIL reset_flags got wrap=%b busy=%b id=%0d exp 0 0 0", wrap0, busy0, id0); end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (gnt0 !== exp_g[k]) begin errors++; $display("FAIL rr_gnt step=%0d got=%b exp=%b", k, gnt0, exp_g[k]); end
      checks++; if (count0 !== 3'(k)) begin errors++; $display("FAIL rr_count step=%0d got=%0d exp=%0d", k, count0, k); end
      tick();
    end
    checks++; if (count0 !== 3'd5 || id0 !== 2'd0 || busy0 !== 1'b1) begin errors++; $display("FAIL rr_end got cnt=%0d id=%0d busy=%b exp 5 0 1", count0, id0, busy0); end
  endtask

  task automatic test_wrap();
    req = '0;
    set_cmd(2, 2, 7); #1; tick();
    checks++; if (count0 !== 3'd7 || count1 !== 3'd7) begin errors++; $display("FAIL wrap_load7 got=%0d/%0d exp=7/7", count0, count1); end
    set_cmd(2, 0, 0); #1;
    checks++; if (gnt0 !== 4'b0100) begin errors++; $display("FAIL wrap_gnt got=%b exp=0100", gnt0); end
    tick();
    checks++; if (count0 !== 3'd0 || wrap0 !== 1'b1 || id0 !== 2'd2) begin errors++; $display("FAIL wrap_inc got cnt=%0d wrap=%b id=%0d exp 0 1 2", count0, wrap0, id0); end
    checks++; if (count1 !== 3'd7 || wrap1 !== 1'b1) begin errors++; $display("FAIL sat_inc got cnt=%0d wrap=%b exp 7 1", count1, wrap1); end
    req = '0; #1; tick();
    checks++; if (wrap0 !== 1'b0 || wrap1 !== 1'b0 || count0 !== 3'd0) begin errors++; $display("FAIL wrap_pulse got wrap=%b/%b cnt=%0d exp 0/0 0", wrap0, wrap1, count0); end
    set_cmd(2, 1, 0); #1; tick();
    checks++; if (count0 !== 3'd7 || wrap0 !== 1'b1) begin errors++; $display("FAIL wrap_dec got cnt=%0d wrap=%b exp 7 1", count0, wrap0); end
    checks++; if (count1 !== 3'd6 || wrap1 !== 1'b0) begin errors++; $display("FAIL sat_dec7 got cnt=%0d wrap=%b exp 6 0", count1, wrap1); end
    set_cmd(2, 3, 0); #1; tick();
    set_cmd(2, 1, 0); #1; tick();
    checks++; if (count1 !== 3'd0 || wrap1 !== 1'b1) begin errors++; $display("FAIL sat_dec0 got cnt=%0d wrap=%b exp 0 1", count1, wrap1); end
    checks++; if (count0 !== 3'd7 || wrap0 !== 1'b1) begin errors++; $display("FAIL wrap_dec0 got cnt=%0d wrap=%b exp 7 1", count0, wrap0); end
    set_cmd(2, 2, 5); #1; tick();
    checks++; if (count0 !== 3'd5 || count1 !== 3'd5 || wrap0 !== 1'b0 || wrap1 !== 1'b0) begin errors++; $display("FAIL load5 got cnt=%0d/%0d wrap=%b/%b exp 5/5 0/0", count0, count1, wrap0, wrap1); end
    req = '0;
  endtask

  task automatic test_load_clear();
    logic [N-1:0] exp_g [3];
    int exp_c [3];
    int exp_i [3];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b1000; exp_g[2] = 4'b0001;
    exp_c[0] = 6; exp_c[1] = 0; exp_c[2] = 6;
    exp_i[0] = 0; exp_i[1] = 3; exp_i[2] = 0;
    rst = 1'b1; req = '0; #1; tick(); rst = 1'b0;
    set_cmd(0, 2, 6); set_cmd(3, 3, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (gnt0 !== exp_g[k]) begin errors++; $display("FAIL lc_gnt step=%0d got=%b exp=%b", k, gnt0, exp_g[k]); end
      tick();
      checks++; if (count0 !== 3'(exp_c[k]) || id0 !== 2'(exp_i[k])) begin errors++; $display("FAIL lc_count step=%0d got cnt=%0d id=%0d exp %0d %0d", k, count0, id0, exp_c[k], exp_i[k]); end
    end
    req = '0;
  endtask

  task automatic test_idle();
    req = '0;
    set_cmd(1, 2, 3); #1; tick();
    req = '0;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++; if (gnt0 !== 4'b0000) begin errors++; $display("FAIL idle_gnt step=%0d got=%b exp=0000", k, gnt0); end
      tick();
      checks++; if (count0 !== 3'd3 || busy0 !== 1'b0 || id0 !== 2'd1 || wrap0 !== 1'b0) begin errors++; $display("FAIL idle_state step=%0d got cnt=%0d busy=%b id=%0d wrap=%b exp 3 0 1 0", k, count0, busy0, id0, wrap0); end
    end
  endtask

  task automatic test_reset_mid();
    req = '0;
    set_cmd(0, 0, 0); #1; tick();
    req = '0;
    set_cmd(0, 0, 0); set_cmd(1, 2, 4);
    rst = 1'b1; #1;
    checks++; if (gnt0 !== 4'b0000) begin errors++; $display("FAIL rstmid_gnt got=%b exp=0000", gnt0); end
    tick();
    checks++; if (count0 !== 3'd0 || id0 !== 2'd0 || busy0 !== 1'b0) begin errors++; $display("FAIL rstmid_state got cnt=%0d id=%0d busy=%b exp 0 0 0", count0, id0, busy0); end
    rst = 1'b0; #1;
    checks++; if (gnt0 !== 4'b0001) begin errors++; $display("FAIL rstmid_ptr got=%b exp=0001", gnt0); end
    tick();
    checks++; if (count0 !== 3'd1 || id0 !== 2'd0) begin errors++; $display("FAIL rstmid_after got cnt=%0d id=%0d exp 1 0", count0, id0); end
    req = '0;
  endtask

  task automatic test_random();
    int w;
    logic [N-1:0] eg;
    req = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) set_cmd(i, int'($urandom_range(0, 3)), int'($urandom_range(0, MAXV)));
      end
      rst = ($urandom_range(0, 39) == 0);
      #1;
      eg = model_gnt();
      checks++; if (gnt0 !== eg || gnt1 !== eg) begin errors++; $display("FAIL rnd_gnt cyc=%0d got=%b/%b exp=%b", c, gnt0, gnt1, eg); end
      w = model_winner();
      tick();
      checks++; if (count0 !== W'(m_cnt0) || wrap0 !== 1'(m_wrap0)) begin errors++; $display("FAIL rnd_wrapctr cyc=%0d got cnt=%0d wrap=%b exp %0d %0d", c, count0, wrap0, m_cnt0, m_wrap0); end
      checks++; if (count1 !== W'(m_cnt1) || wrap1 !== 1'(m_wrap1)) begin errors++; $display("FAIL rnd_satctr cyc=%0d got cnt=%0d wrap=%b exp %0d %0d", c, count1, wrap1, m_cnt1, m_wrap1); end
      checks++; if (id0 !== IDW'(m_id) || id1 !== IDW'(m_id) || busy0 !== 1'(m_busy) || busy1 !== 1'(m_busy)) begin errors++; $display("FAIL rnd_idbusy cyc=%0d got id=%0d/%0d busy=%b/%b exp %0d %0d", c, id0, id1, busy0, busy1, m_id, m_busy); end
      if (w >= 0) req[w] = 1'b0;
    end
    rst = 1'b0;
    req = '0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_load_clear();
    test_idle();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
